// File: rtl/bram_dual_be_if.sv
// Bus bundle for bram_dual_be.
//   master: drives the write port (write_i, wstrb_i, waddr_i, data_i) and the read request
//           (read_i, raddr_i); observes data_o, valid_o, busy_o.
//   slave:  the RAM side of the same signals.
// AddrW and XLEN must match memSize_p and XLEN of the attached bram_dual_be.
interface bram_dual_be_if #(
  parameter int unsigned AddrW = 6,
  parameter int unsigned XLEN  = 32
);
  logic                  write_i;
  logic [XLEN/8-1:0]     wstrb_i;
  logic [AddrW-1:0]      waddr_i;
  logic [XLEN-1:0]       data_i;
  logic                  read_i;
  logic [AddrW-1:0]      raddr_i;
  logic [XLEN-1:0]       data_o;
  logic                  valid_o;
  logic                  busy_o;

  modport master (
    output write_i, wstrb_i, waddr_i, data_i, read_i, raddr_i,
    input  data_o, valid_o, busy_o
  );

  modport slave (
    input  write_i, wstrb_i, waddr_i, data_i, read_i, raddr_i,
    output data_o, valid_o, busy_o
  );
endinterface

// File: rtl/bram_dual_be.sv
// Simple-dual-port inferred block RAM with byte-strobed writes.
//   clk_i  : clock, all logic on posedge
//   rst_i  : synchronous active-high reset
//   bus    : bram_dual_be_if.slave
//            write_i/wstrb_i/waddr_i/data_i  byte-strobed write port
//            read_i/raddr_i                  read request
//            data_o                          read data, held until the next read completes
//            valid_o                         one-cycle pulse per completed read
//            busy_o                          clear sweep in progress, requests ignored
// A read that collides with a same-cycle write returns the written bytes merged over the old
// word. Read latency is 1 cycle, or 2 with OUT_REG_p=1. With CLEAR_ON_RESET_p=1 every word is
// zeroed after reset, one word per cycle, before traffic is accepted.
module bram_dual_be #(
  parameter int unsigned memSize_p        = 6,
  parameter int unsigned XLEN             = 32,
  parameter int unsigned OUT_REG_p        = 0,
  parameter int unsigned CLEAR_ON_RESET_p = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  bram_dual_be_if.slave  bus
);

  localparam int unsigned NumBytes = XLEN / 8;
  localparam int unsigned Depth    = 2 ** memSize_p;
  localparam logic [memSize_p-1:0] LastAddr = {memSize_p{1'b1}};

  typedef enum logic {StClear, StReady} state_e;

  localparam state_e ResetState = (CLEAR_ON_RESET_p != 0) ? StClear : StReady;

  state_e                 state_q;
  logic [memSize_p-1:0]   clr_cnt_q;
  logic                   busy_q;

  logic [XLEN-1:0]        mem_q [Depth];

  logic                   wr_en;
  logic                   rd_en;
  logic [NumBytes-1:0]    hit_d;

  logic [XLEN-1:0]        rd_mem_q;
  logic [XLEN-1:0]        rd_wdata_q;
  logic [NumBytes-1:0]    rd_hit_q;
  logic                   rd_valid_q;
  logic [XLEN-1:0]        merged;

  // Control FSM: clear sweep, then normal operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ResetState;
      clr_cnt_q <= '0;
      busy_q    <= (CLEAR_ON_RESET_p != 0);
    end else begin
      case (state_q)
        StClear: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LastAddr) begin
            state_q <= StReady;
            busy_q  <= 1'b0;
          end
        end
        StReady: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= ResetState;
        end
      endcase
    end
  end

  assign wr_en = (state_q == StReady) && bus.write_i && !rst_i;
  assign rd_en = (state_q == StReady) && bus.read_i && !rst_i;

  // Bytes of the current write that land on the word being read this cycle.
  assign hit_d = bus.wstrb_i & {NumBytes{bus.write_i && (bus.waddr_i == bus.raddr_i)}};

  // Array has no reset; only the clear sweep initialises it.
  always_ff @(posedge clk_i) begin
    if (state_q == StClear) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (bus.wstrb_i[k]) begin
          mem_q[bus.waddr_i][8*k +: 8] <= bus.data_i[8*k +: 8];
        end
      end
    end
  end

  // Read stage 1: old word plus the colliding write data and its byte mask.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_mem_q   <= '0;
      rd_wdata_q <= '0;
      rd_hit_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_mem_q   <= mem_q[bus.raddr_i];
        rd_wdata_q <= bus.data_i;
        rd_hit_q   <= hit_d;
      end
    end
  end

  always_comb begin
    merged = rd_mem_q;
    for (int k = 0; k < NumBytes; k++) begin
      if (rd_hit_q[k]) begin
        merged[8*k +: 8] = rd_wdata_q[8*k +: 8];
      end
    end
  end

  if (OUT_REG_p != 0) begin : g_out_reg
    logic [XLEN-1:0] out_q;
    logic            out_valid_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= rd_valid_q;
        if (rd_valid_q) begin
          out_q <= merged;
        end
      end
    end

    assign bus.data_o  = out_q;
    assign bus.valid_o = out_valid_q;
  end else begin : g_no_out_reg
    // Stage-1 registers only change on an accepted read, so data_o holds in between.
    assign bus.data_o  = merged;
    assign bus.valid_o = rd_valid_q;
  end

  assign bus.busy_o = busy_q;

endmodule
